tt_mux_sel_seq: RTL and testbench

- Control-side sequencer that drives the three mux-control pads: ctrl_sel_rst_n, ctrl_sel_inc and ctrl_ena.
- Sits directly upstream of the chip's address counter and basic mux.
- Takes a "select project N, enable/disable" request over a valid/ready handshake and emits the matching reset/increment pulse train with enable gating.
- Keeps a shadow copy of the on-chip counter so it can skip the counter reset when the target address is above the current one.

---
 rtl/tt_mux_sel_seq_if.sv | 24 ++
 rtl/tt_mux_sel_seq.sv | 168 ++++++++++++++++
 tb/tb_tt_mux_sel_seq.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_mux_sel_seq_if.sv
// Request channel into the mux-select sequencer: target project address plus
// enable flag, transferred on a valid/ready handshake.
interface tt_mux_sel_seq_if #(
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ena;

    modport master (
        output req_valid,
        output req_addr,
        output req_ena,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_ena,
        output req_ready
    );
endinterface

// File: rtl/tt_mux_sel_seq.sv
// Drives the mux-control pads (counter reset, counter increment, enable) so the
// on-chip address counter lands on a requested project, tracking it in a shadow.
module tt_mux_sel_seq #(
    parameter int ADDR_W        = 5,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    tt_mux_sel_seq_if.slave   req,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    localparam int MAX_CYC = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [3:0] {
        INIT,
        IDLE,
        DISABLE,
        CRST,
        CREL,
        INC_HI,
        INC_LO,
        SETTLE,
        ENABLE
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] tgt_addr, tgt_addr_nxt;
    logic [ADDR_W-1:0] cur_addr_nxt;
    logic              tgt_ena, tgt_ena_nxt;
    logic              ctrl_ena_nxt;
    logic              req_ready_q;
    logic              pulse_last;
    logic              settle_last;

    assign req.req_ready = req_ready_q;
    assign pulse_last    = (cnt == PULSE_LAST);
    assign settle_last   = (cnt == SETTLE_LAST);

    // Next-state logic; cnt times the current phase and restarts on every transition.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + CNT_W'(1);
        cur_addr_nxt = cur_addr;
        tgt_addr_nxt = tgt_addr;
        tgt_ena_nxt  = tgt_ena;
        ctrl_ena_nxt = ctrl_ena;
        case (state)
            INIT: begin
                cur_addr_nxt = '0;
                if (pulse_last) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            IDLE: begin
                cnt_nxt = '0;
                if (req.req_valid) begin
                    tgt_addr_nxt = req.req_addr;
                    tgt_ena_nxt  = req.req_ena;
                    // Re-selecting the current project leaves the enable untouched.
                    if (req.req_ena && (req.req_addr == cur_addr)) begin
                        state_nxt = SETTLE;
                    end else begin
                        state_nxt    = DISABLE;
                        ctrl_ena_nxt = 1'b0;
                    end
                end
            end
            DISABLE: begin
                if (settle_last) begin
                    cnt_nxt = '0;
                    if (!tgt_ena) begin
                        state_nxt    = ENABLE;
                        ctrl_ena_nxt = tgt_ena;
                    end else if (tgt_addr < cur_addr) begin
                        state_nxt = CRST;
                    end else if (tgt_addr == cur_addr) begin
                        state_nxt = SETTLE;
                    end else begin
                        state_nxt = INC_HI;
                    end
                end
            end
            CRST: begin
                if (pulse_last) begin
                    cnt_nxt      = '0;
                    cur_addr_nxt = '0;
                    state_nxt    = CREL;
                end
            end
            CREL: begin
                if (pulse_last) begin
                    cnt_nxt   = '0;
                    state_nxt = (tgt_addr == cur_addr) ? SETTLE : INC_HI;
                end
            end
            INC_HI: begin
                if (pulse_last) begin
                    cnt_nxt      = '0;
                    cur_addr_nxt = cur_addr + ADDR_W'(1);
                    state_nxt    = INC_LO;
                end
            end
            INC_LO: begin
                if (pulse_last) begin
                    cnt_nxt   = '0;
                    state_nxt = (tgt_addr == cur_addr) ? SETTLE : INC_HI;
                end
            end
            SETTLE: begin
                if (settle_last) begin
                    cnt_nxt      = '0;
                    state_nxt    = ENABLE;
                    ctrl_ena_nxt = tgt_ena;
                end
            end
            ENABLE: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = INIT;
            end
        endcase
    end

    // Pad outputs are registered from the next state so they never glitch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= INIT;
            cnt            <= '0;
            cur_addr       <= '0;
            tgt_addr       <= '0;
            tgt_ena        <= 1'b0;
            ctrl_ena       <= 1'b0;
            ctrl_sel_rst_n <= 1'b0;
            ctrl_sel_inc   <= 1'b0;
            req_ready_q    <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            cur_addr       <= cur_addr_nxt;
            tgt_addr       <= tgt_addr_nxt;
            tgt_ena        <= tgt_ena_nxt;
            ctrl_ena       <= ctrl_ena_nxt;
            ctrl_sel_rst_n <= !((state_nxt == INIT) || (state_nxt == CRST));
            ctrl_sel_inc   <= (state_nxt == INC_HI);
            req_ready_q    <= (state_nxt == IDLE);
            busy           <= (state_nxt != IDLE);
            done           <= (state_nxt == ENABLE);
        end
    end

endmodule

// File: tb/tb_tt_mux_sel_seq.sv
// Scoreboard bench for tt_mux_sel_seq: directed requests push hand-computed
// expectations, an independent monitor checks them when done pulses.
module tb_tt_mux_sel_seq;

    localparam int ADDR_W = 5;
    localparam int PULSE  = 2;
    localparam int SETTLE = 4;

    typedef struct {
        int lat;
        int addr;
        int ena;
        int n_inc;
        int n_rst;
        int ena_e0;
        int keep;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] cur_addr;
    logic              ctrl_sel_rst_n;
    logic              ctrl_sel_inc;
    logic              ctrl_ena;

    tt_mux_sel_seq_if #(.ADDR_W(ADDR_W)) req_if ();

    tt_mux_sel_seq #(
        .ADDR_W        (ADDR_W),
        .PULSE_CYCLES  (PULSE),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req_if),
        .busy           (busy),
        .done           (done),
        .cur_addr       (cur_addr),
        .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc   (ctrl_sel_inc),
        .ctrl_ena       (ctrl_ena)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    int   cyc = 0;
    int   e0 = 0;
    int   n_acc = 0;
    int   inc_cnt = 0;
    int   rst_cnt = 0;
    int   inc_run = 0;
    int   bad_width = 0;
    int   ena_dropped = 0;
    int   inv_viol = 0;
    logic chk_e0 = 1'b0;
    logic prev_inc = 1'b0;
    logic prev_rst = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Acceptance edges: DUT registers still hold pre-edge values here.
    always @(posedge clk) begin
        cyc++;
        if (rst_n && req_if.req_valid && req_if.req_ready) begin
            e0          = cyc;
            n_acc++;
            inc_cnt     = 0;
            rst_cnt     = 0;
            bad_width   = 0;
            ena_dropped = 0;
            chk_e0      = 1'b1;
        end
    end

    // Monitor: pulse accounting, invariants, and scoreboard pops on done.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ((!ctrl_sel_rst_n && ctrl_sel_inc) ||
                      (ctrl_ena && (ctrl_sel_inc || !ctrl_sel_rst_n))))
            inv_viol++;
        if (ctrl_sel_inc && !prev_inc) begin
            inc_cnt++;
            inc_run = 1;
        end else if (ctrl_sel_inc) begin
            inc_run++;
        end else if (prev_inc && inc_run != PULSE) begin
            bad_width++;
        end
        if (!ctrl_sel_rst_n && prev_rst) rst_cnt++;
        if (!ctrl_ena) ena_dropped = 1;
        if (chk_e0 && sb.size() > 0) checkOutput("ena_at_accept", int'(ctrl_ena), sb[0].ena_e0);
        chk_e0 = 1'b0;
        if (done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", int'(done), 0);
            end else begin
                e = sb.pop_front();
                checkOutput("done_latency", cyc - e0, e.lat);
                checkOutput("cur_addr", int'(cur_addr), e.addr);
                checkOutput("ctrl_ena", int'(ctrl_ena), e.ena);
                checkOutput("inc_pulses", inc_cnt, e.n_inc);
                checkOutput("rst_pulses", rst_cnt, e.n_rst);
                checkOutput("inc_width", bad_width, 0);
                if (e.keep != 0) checkOutput("ena_glitch", ena_dropped, 0);
            end
        end
        prev_inc = ctrl_sel_inc;
        prev_rst = ctrl_sel_rst_n;
    end

    task automatic waitAccept();
        int n = 0;
        while (!req_if.req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) checkOutput("accept_timeout", n, 0);
        @(posedge clk);
    endtask

    task automatic applyStimulus(input int addr, input int ena, input exp_t e);
        sb.push_back(e);
        @(negedge clk);
        req_if.req_valid = 1'b1;
        req_if.req_addr  = ADDR_W'(addr);
        req_if.req_ena   = ena[0];
        waitAccept();
        @(negedge clk);
        req_if.req_valid = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (sb.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checkOutput("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int base;
        req_if.req_valid = 1'b0;
        req_if.req_addr  = '0;
        req_if.req_ena   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_sel_rst_n", int'(ctrl_sel_rst_n), 0);
        checkOutput("rst_sel_inc", int'(ctrl_sel_inc), 0);
        checkOutput("rst_ena", int'(ctrl_ena), 0);
        checkOutput("rst_cur_addr", int'(cur_addr), 0);
        checkOutput("rst_ready", int'(req_if.req_ready), 0);
        checkOutput("rst_busy", int'(busy), 1);
        checkOutput("rst_done", int'(done), 0);

        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ctrl_sel_rst_n && n < 10);
        checkOutput("init_low_cycles", n, 2);
        checkOutput("idle_ready", int'(req_if.req_ready), 1);
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("idle_cur_addr", int'(cur_addr), 0);
        checkOutput("idle_ena", int'(ctrl_ena), 0);

        applyStimulus(3, 1, exp_t'{20, 3, 1, 3, 0, 0, 0});
        waitDone();
        applyStimulus(1, 1, exp_t'{16, 1, 1, 1, 1, 0, 0});
        waitDone();
        applyStimulus(1, 1, exp_t'{4, 1, 1, 0, 0, 1, 1});
        waitDone();
        applyStimulus(7, 0, exp_t'{4, 1, 0, 0, 0, 0, 0});
        waitDone();
        applyStimulus(0, 1, exp_t'{12, 0, 1, 0, 1, 0, 0});
        waitDone();

        // Held request: second copy must wait until the first completes.
        base = n_acc;
        sb.push_back(exp_t'{132, 31, 1, 31, 0, 0, 0});
        sb.push_back(exp_t'{4, 31, 1, 0, 0, 1, 1});
        @(negedge clk);
        req_if.req_valid = 1'b1;
        req_if.req_addr  = 5'd31;
        req_if.req_ena   = 1'b1;
        waitAccept();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("ready_while_busy", int'(req_if.req_ready), 0);
        end
        checkOutput("no_early_accept", n_acc - base, 1);
        while (sb.size() > 1 && n_acc - base < 2 && cyc < 5000) @(negedge clk);
        waitAccept();
        @(negedge clk);
        req_if.req_valid = 1'b0;
        checkOutput("accept_count", n_acc - base, 2);
        waitDone();

        // Synchronous reset while an increment pulse is high.
        applyStimulus(10, 1, exp_t'{0, 10, 1, 0, 0, 0, 0});
        n = 0;
        while (!ctrl_sel_inc && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_inc_hi", int'(ctrl_sel_inc), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_ena", int'(ctrl_ena), 0);
        checkOutput("midrst_inc", int'(ctrl_sel_inc), 0);
        checkOutput("midrst_sel_rst_n", int'(ctrl_sel_rst_n), 0);
        checkOutput("midrst_cur_addr", int'(cur_addr), 0);
        checkOutput("midrst_busy", int'(busy), 1);
        checkOutput("midrst_done", int'(done), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("no_done_after_rst", int'(done), 0);
        end

        applyStimulus(2, 1, exp_t'{16, 2, 1, 2, 0, 0, 0});
        waitDone();

        checkOutput("invariant_violations", inv_viol, 0);
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
